uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the existing 8N1 transmitter, sharing its F/BAUD/N parameter set and bit-period formula. It oversamples the asynchronous rx line with the system clock and samples each bit at mid-period. Assembled words are presented to a downstream consumer over a valid/ready handshake. It flags framing errors and overruns, and sits between the board RX pin and the consuming logic (e.g. a FIFO or command parser).

Parameters:
F, 8000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
N, 8, data bits per frame (1 start, N data LSB first, 1 stop, no parity)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
data  output  N  received word, stable while valid=1
valid  output  1  data holds an unconsumed word
ready  input  1  consumer accepts data when valid&ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good frame dropped because valid was still 1

Behaviour:
- Bit period P = (F+BAUD/2)/BAUD clocks (69 at defaults); half period H = P/2, truncated (34).
- rx passes through a 2-FF synchronizer (rx_s). Both FFs reset to 1. This adds 2 cycles of latency on all edge timing.
- Reset (rst=0, async): state IDLE, valid=0, data=0, frame_err=0, overrun=0, counters=0, shift register=0. Reset mid-frame abandons the frame with no flags. After release, reception starts only on a fresh falling edge.
- IDLE: wait for rx_s going 1->0 (previous sample 1, current 0). Then clear the counter and go to START. A line that is low at reset release, or still low after a frame error, does not trigger a start.
- START: count H cycles, then sample rx_s.
  - rx_s=1: false start (glitch), return to IDLE with no flags.
  - rx_s=0: clear the bit counter and go to DATA.
- DATA: every P cycles, sample rx_s into shift bit i, for i = 0..N-1, LSB first. After bit N-1 is sampled, go to STOP.
- STOP: after P cycles, sample rx_s, then return to IDLE in the next cycle. Returning at mid-stop allows back-to-back frames.
  - Sample 1 and (valid=0 or ready=1): data<=shift, valid<=1 on the next edge.
  - Sample 1 and valid=1 and ready=0: keep the old data, pulse overrun for 1 cycle, discard the new word.
  - Sample 0: discard the word, pulse frame_err for 1 cycle, data/valid unchanged.
- Handshake: valid stays 1 until a cycle with valid&ready=1, then clears on the next edge unless a new word loads in that same cycle.
  - Consume and load in the same cycle: valid stays 1, data takes the new word, no overrun.
  - ready is ignored while valid=0.
- Latency: valid rises 1 cycle after the stop-bit sample point. That is about 2 (sync) + H + N*P + P + 1 clocks after the falling edge on rx: 2+34+552+69+1 = 658 at defaults.
- Counters are sized to hold P-1 and N-1. No wrap beyond those values. An unused state encoding returns to IDLE.
- frame_err and overrun are never asserted in the same cycle.

Test Plan:
- Single frame 0xA5 at P=69, ready=1 -> one valid pulse, data=0xA5, valid rises 658±1 clocks after rx falls, no flags.
- Back-to-back 0x00,0xFF,0x3C with zero idle between stop and next start, ready held 0 until all three are received -> data=0x00 kept, valid=1, overrun pulses twice. Then ready=1 for 1 cycle -> valid=0.
- Stop bit driven low on frame 0x55 -> frame_err pulses 1 cycle, valid stays 0. A line held low afterwards causes no new start. A next valid frame 0x12 after line idle -> data=0x12.
- 20-clock low glitch on idle rx -> shorter than H, rejected in START, no valid, no flags, back to IDLE.
- valid=1 with ready asserted exactly in the cycle a new 0x7E completes -> valid remains 1, data=0x7E, no overrun.
- rst pulsed low mid-DATA of frame 0x99 -> valid=0, data=0 immediately. The rest of the frame is ignored (no start re-detected mid-frame unless a falling edge occurs). A following frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rx with clk, samples each bit at mid-period and
// hands assembled words to a consumer over valid/ready, flagging framing errors and overruns.
module uart_rx #(
   parameter int F    = 8000000,
   parameter int BAUD = 115200,
   parameter int N    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx,
   output logic [N-1:0] data,
   output logic         valid,
   input  logic         ready,
   output logic         frame_err,
   output logic         overrun
);

   localparam int P  = (F + BAUD / 2) / BAUD;
   localparam int H  = P / 2;
   localparam int CW = (P > 1) ? $clog2(P) : 1;
   localparam int BW = (N > 1) ? $clog2(N) : 1;

   localparam logic [CW-1:0] P_LAST = CW'(P - 1);
   localparam logic [CW-1:0] H_LAST = CW'(H - 1);
   localparam logic [BW-1:0] N_LAST = BW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic          rx_meta_r;
   logic          rx_sync_r;
   logic          rx_prev_r;
   logic [1:0]    settle_r;

   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;
   logic [BW-1:0] bit_r;
   logic [BW-1:0] bit_s;
   logic [N-1:0]  shift_r;
   logic [N-1:0]  shift_s;
   logic [N-1:0]  data_s;
   logic          valid_s;
   logic          frame_err_s;
   logic          overrun_s;

   // Synchronizer and edge-history register; history is held low until the
   // synchronizer has flushed its reset value, so a line low at release never looks like an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b0;
         settle_r  <= 2'd0;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= (settle_r == 2'd2) ? rx_sync_r : 1'b0;
         settle_r  <= (settle_r == 2'd2) ? 2'd2 : settle_r + 2'd1;
      end
   end

   // Receive FSM next-state, datapath and handshake logic.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      bit_s       = bit_r;
      shift_s     = shift_r;
      data_s      = data;
      frame_err_s = 1'b0;
      overrun_s   = 1'b0;

      if (valid && ready) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid;
      end

      case (state_r)
         IDLE: begin
            cnt_s = {CW{1'b0}};
            bit_s = {BW{1'b0}};
            if (rx_prev_r && !rx_sync_r) begin
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (cnt_r == H_LAST) begin
               cnt_s = {CW{1'b0}};
               bit_s = {BW{1'b0}};
               if (rx_sync_r) begin
                  state_s = IDLE;
               end else begin
                  state_s = DATA;
               end
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         DATA: begin
            if (cnt_r == P_LAST) begin
               cnt_s          = {CW{1'b0}};
               shift_s[bit_r] = rx_sync_r;
               if (bit_r == N_LAST) begin
                  state_s = STOP;
               end else begin
                  bit_s = bit_r + BW'(1);
               end
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         STOP: begin
            if (cnt_r == P_LAST) begin
               cnt_s   = {CW{1'b0}};
               state_s = IDLE;
               if (!rx_sync_r) begin
                  frame_err_s = 1'b1;
               end else if (!valid || ready) begin
                  // a same-cycle consume frees the slot, so this is a load, not an overrun
                  data_s  = shift_r;
                  valid_s = 1'b1;
               end else begin
                  overrun_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
            bit_s   = {BW{1'b0}};
         end
      endcase
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         cnt_r     <= {CW{1'b0}};
         bit_r     <= {BW{1'b0}};
         shift_r   <= {N{1'b0}};
         data      <= {N{1'b0}};
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_r     <= bit_s;
         shift_r   <= shift_s;
         data      <= data_s;
         valid     <= valid_s;
         frame_err <= frame_err_s;
         overrun   <= overrun_s;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of single frames with expected results,
// then hand-written sequences for latency, back-to-back, framing, glitch, handshake and reset cases.
module tb_uart_rx;

   localparam int F    = 8000000;
   localparam int BAUD = 115200;
   localparam int N    = 8;
   localparam int P    = 69;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;

   int n_cmp  = 0;
   int n_fail = 0;
   int ferr_n = 0;
   int ovr_n  = 0;
   int vrise_n = 0;
   logic valid_q = 1'b0;

   uart_rx #(.F(F), .BAUD(BAUD), .N(N)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
      .ready(ready), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) ferr_n = ferr_n + 1;
      if (overrun) ovr_n = ovr_n + 1;
      if (valid && !valid_q) vrise_n = vrise_n + 1;
      valid_q = valid;
      if (frame_err || overrun) begin
         n_cmp = n_cmp + 1;
         if (frame_err && overrun) begin
            n_fail = n_fail + 1;
            $display("FAIL flags_exclusive: got frame_err=1 overrun=1, required not both");
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (P) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (P) @(negedge clk);
      end
      rx = stop;
      repeat (P) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle(4);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       rdy;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_ferr;
      int         exp_ovr;
      int         exp_vrise;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int b_f, b_o, b_v, lat;
      logic [7:0] seen;

      tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 0, 0, 1};
      tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 0, 1};
      tbl[2] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 1, 0};
      tbl[3] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h3C, 1, 0, 0};
      tbl[4] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81, 0, 0, 1};
      tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h81, 1, 0, 0};
      tbl[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 0, 1};

      rst = 1'b0; rx = 1'b1; ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_valid", valid, 0);
      chk("reset_data", data, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_overrun", overrun, 0);
      rst = 1'b1;
      idle(4);

      for (int i = 0; i < 7; i++) begin
         ready = tbl[i].rdy;
         b_f = ferr_n; b_o = ovr_n; b_v = vrise_n;
         send_frame(tbl[i].d, tbl[i].stop);
         idle(2 * P);
         chk($sformatf("tbl%0d_valid", i), valid, tbl[i].exp_valid);
         chk($sformatf("tbl%0d_data", i), data, tbl[i].exp_data);
         chk($sformatf("tbl%0d_frame_err", i), ferr_n - b_f, tbl[i].exp_ferr);
         chk($sformatf("tbl%0d_overrun", i), ovr_n - b_o, tbl[i].exp_ovr);
         chk($sformatf("tbl%0d_valid_rises", i), vrise_n - b_v, tbl[i].exp_vrise);
      end

      // latency of a single frame with ready held high
      do_reset();
      ready = 1'b1;
      b_f = ferr_n; b_o = ovr_n; b_v = vrise_n;
      lat = 0; seen = 8'h00;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (!valid && lat < 800) begin
               @(negedge clk);
               lat = lat + 1;
            end
            seen = data;
         end
      join
      chk("lat_in_window", int'(lat >= 657 && lat <= 659), 1);
      chk("lat_data", seen, 8'hA5);
      idle(P);
      chk("lat_valid_after", valid, 0);
      chk("lat_valid_rises", vrise_n - b_v, 1);
      chk("lat_flags", (ferr_n - b_f) + (ovr_n - b_o), 0);

      // back-to-back frames, consumer stalled
      do_reset();
      ready = 1'b0;
      b_f = ferr_n; b_o = ovr_n;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      idle(2 * P);
      chk("b2b_valid", valid, 1);
      chk("b2b_data", data, 8'h00);
      chk("b2b_overrun", ovr_n - b_o, 2);
      chk("b2b_frame_err", ferr_n - b_f, 0);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("b2b_consumed", valid, 0);

      // framing error, line held low, then a good frame
      do_reset();
      b_f = ferr_n; b_v = vrise_n;
      send_frame(8'h55, 1'b0);
      repeat (3 * P) @(negedge clk);
      idle(2 * P);
      chk("ferr_pulse", ferr_n - b_f, 1);
      chk("ferr_no_valid", vrise_n - b_v, 0);
      chk("ferr_valid", valid, 0);
      send_frame(8'h12, 1'b1);
      idle(2 * P);
      chk("ferr_next_data", data, 8'h12);
      chk("ferr_next_valid", valid, 1);

      // short glitch on idle line
      do_reset();
      b_f = ferr_n; b_o = ovr_n; b_v = vrise_n;
      rx = 1'b0;
      repeat (20) @(negedge clk);
      idle(2 * P);
      chk("glitch_valid_rises", vrise_n - b_v, 0);
      chk("glitch_flags", (ferr_n - b_f) + (ovr_n - b_o), 0);
      send_frame(8'h5A, 1'b1);
      idle(2 * P);
      chk("glitch_next_data", data, 8'h5A);

      // consume in the same cycle a new word completes
      do_reset();
      ready = 1'b0;
      send_frame(8'h11, 1'b1);
      idle(2 * P);
      chk("same_pre_data", data, 8'h11);
      b_o = ovr_n; b_v = vrise_n;
      fork
         send_frame(8'h7E, 1'b1);
         begin
            repeat (657) @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
         end
      join
      idle(2 * P);
      chk("same_valid", valid, 1);
      chk("same_data", data, 8'h7E);
      chk("same_overrun", ovr_n - b_o, 0);
      chk("same_no_gap", vrise_n - b_v, 0);

      // reset in the middle of the last data bit
      do_reset();
      ready = 1'b0;
      send_frame(8'h66, 1'b1);
      idle(2 * P);
      chk("rst_pre_valid", valid, 1);
      b_f = ferr_n; b_v = vrise_n;
      fork
         send_frame(8'h99, 1'b1);
         begin
            repeat (580) @(negedge clk);
            rst = 1'b0;
            #1;
            chk("rst_valid_now", valid, 0);
            chk("rst_data_now", data, 0);
            repeat (5) @(negedge clk);
            rst = 1'b1;
         end
      join
      idle(2 * P);
      chk("rst_no_valid", vrise_n - b_v, 0);
      chk("rst_no_ferr", ferr_n - b_f, 0);
      send_frame(8'h42, 1'b1);
      idle(2 * P);
      chk("rst_next_valid", valid, 1);
      chk("rst_next_data", data, 8'h42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
